// File: rtl/timer_arb_pkg.sv
// Shared definitions for the timer arbiter slice.
//   state_e        : arbiter FSM states (IDLE, RUN)
//   IDX_W / OH_W   : requester index width and one-hot width (up to 8 requesters)
//   uflow_pos()    : bit position of the underflow flag for a given magnitude width
//   onehot_to_idx(): encodes a one-hot (or zero) vector into a binary index
package timer_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Index and one-hot widths sized for the largest supported requester count.
  localparam int IDX_W = 3;
  localparam int OH_W  = 8;

  // The counter carries one extra bit above its magnitude; it only sets when
  // the count steps below zero, so it doubles as the underflow flag.
  function automatic int uflow_pos(input int width);
    return width;
  endfunction

  // OR-encoder: valid for one-hot inputs, returns 0 for an all-zero input.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [OH_W-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = {IDX_W{1'b0}};
    for (int i = 0; i < OH_W; i++) begin
      if (oh[i]) begin
        idx = idx | IDX_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
//   req   : request vector, one bit per client
//   ptr   : index where the search starts (searching upward, wrapping)
//   valid : at least one request is pending
//   idx   : winning client index
module rr_picker
  import timer_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  logic [NREQ-1:0]  rot_s;
  logic [NREQ-1:0]  lowest_s;
  logic [IDX_W-1:0] off_s;
  logic [IDX_W:0]   sum_s;

  // Rotate so the pointer position lands on bit 0, then isolate the lowest
  // set bit: that is the first requester at or after the pointer.
  always_comb begin
    rot_s    = NREQ'({req, req} >> ptr);
    lowest_s = rot_s & (~rot_s + NREQ'(1));
    off_s    = onehot_to_idx(OH_W'(lowest_s));
    valid    = |req;
  end

  // Undo the rotation: winner = (ptr + offset) mod NREQ.
  always_comb begin
    sum_s = {1'b0, ptr} + {1'b0, off_s};
    if (sum_s >= (IDX_W+1)'(NREQ)) begin
      idx = IDX_W'(sum_s - (IDX_W+1)'(NREQ));
    end else begin
      idx = sum_s[IDX_W-1:0];
    end
  end

endmodule

// File: rtl/timer_arbiter.sv
// Shares one loadable down-counter between NREQ requesters. The counter is
// granted round-robin, loaded with the winner's length, counts down to
// underflow, then pulses the winner's done and returns to idle.
//   clk   : clock
//   rst   : synchronous active-high reset
//   req   : level request per client
//   len   : requested length per client, client i at [i*WIDTH +: WIDTH]
//   grant : one-hot owner of the counter, zero when idle
//   done  : one-cycle pulse to the owner when its interval expires
//   busy  : high while an interval is running
//   count : counter magnitude (without the underflow bit), zero when idle
module timer_arbiter
  import timer_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] len,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic [WIDTH-1:0]      count
);

  localparam int UFLOW = uflow_pos(WIDTH);

  state_e           state_r, state_nx;
  logic [NREQ-1:0]  grant_r, grant_nx;
  logic [NREQ-1:0]  done_r, done_nx;
  logic             busy_r, busy_nx;
  logic [WIDTH:0]   counter_r, counter_nx;
  logic [IDX_W-1:0] ptr_r, ptr_nx;

  logic             pick_valid_s;
  logic [IDX_W-1:0] pick_idx_s;
  logic [NREQ-1:0]  pick_oh_s;
  logic [WIDTH-1:0] len_sel_s;
  logic [IDX_W-1:0] ptr_wrap_s;
  logic             owner_req_s;

  rr_picker #(
    .NREQ(NREQ)
  ) u_picker (
    .req   (req),
    .ptr   (ptr_r),
    .valid (pick_valid_s),
    .idx   (pick_idx_s)
  );

  // Decode the winner: one-hot grant, its length field, and the pointer
  // position just past it.
  always_comb begin
    pick_oh_s = {NREQ{1'b0}};
    len_sel_s = {WIDTH{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx_s == IDX_W'(i)) begin
        pick_oh_s[i] = 1'b1;
        len_sel_s    = len[i*WIDTH +: WIDTH];
      end else begin
        pick_oh_s[i] = 1'b0;
      end
    end
    if (pick_idx_s == IDX_W'(NREQ-1)) begin
      ptr_wrap_s = {IDX_W{1'b0}};
    end else begin
      ptr_wrap_s = pick_idx_s + IDX_W'(1);
    end
  end

  // The owner still wants the counter while its req bit stays high.
  always_comb begin
    owner_req_s = |(req & grant_r);
  end

  // Next-state and next-output logic. The abort test precedes the underflow
  // test so a dropped request never produces a done pulse.
  always_comb begin
    state_nx   = state_r;
    grant_nx   = grant_r;
    done_nx    = {NREQ{1'b0}};
    counter_nx = counter_r;
    ptr_nx     = ptr_r;
    case (state_r)
      IDLE: begin
        if (pick_valid_s) begin
          state_nx   = RUN;
          grant_nx   = pick_oh_s;
          counter_nx = {1'b0, len_sel_s};
          ptr_nx     = ptr_wrap_s;
        end else begin
          grant_nx   = {NREQ{1'b0}};
          counter_nx = {(WIDTH+1){1'b0}};
        end
      end
      RUN: begin
        if (!owner_req_s) begin
          state_nx   = IDLE;
          grant_nx   = {NREQ{1'b0}};
          counter_nx = {(WIDTH+1){1'b0}};
        end else if (counter_r[UFLOW]) begin
          state_nx   = IDLE;
          done_nx    = grant_r;
          grant_nx   = {NREQ{1'b0}};
          counter_nx = {(WIDTH+1){1'b0}};
        end else begin
          counter_nx = counter_r - (WIDTH+1)'(1);
        end
      end
      default: begin
        state_nx   = IDLE;
        grant_nx   = {NREQ{1'b0}};
        counter_nx = {(WIDTH+1){1'b0}};
      end
    endcase
    busy_nx = (state_nx == RUN);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      grant_r   <= {NREQ{1'b0}};
      done_r    <= {NREQ{1'b0}};
      busy_r    <= 1'b0;
      counter_r <= {(WIDTH+1){1'b0}};
      ptr_r     <= {IDX_W{1'b0}};
    end else begin
      state_r   <= state_nx;
      grant_r   <= grant_nx;
      done_r    <= done_nx;
      busy_r    <= busy_nx;
      counter_r <= counter_nx;
      ptr_r     <= ptr_nx;
    end
  end

  assign grant = grant_r;
  assign done  = done_r;
  assign busy  = busy_r;
  assign count = counter_r[WIDTH-1:0];

endmodule

// File: tb/tb_timer_arbiter.sv
// Self-checking bench for timer_arbiter: a vector table, directed multi-cycle
// sequences, and randomized traffic compared against a transaction-level model.
module tb_timer_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] len;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       done;
  logic                  busy;
  logic [WIDTH-1:0]      count;

  int total = 0;
  int bad   = 0;

  // Model: owner (-1 when idle), its length, cycles since grant, pointer,
  // and which client (if any) shows done this cycle.
  int m_owner = -1;
  int m_len   = 0;
  int m_el    = 0;
  int m_ptr   = 0;
  int m_done  = -1;

  typedef struct {
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] len;
    logic [NREQ-1:0]       grant;
    logic [NREQ-1:0]       done;
    logic                  busy;
    logic [WIDTH-1:0]      count;
  } vec_t;

  vec_t vt[12];

  logic [NREQ-1:0]       q;
  logic [NREQ*WIDTH-1:0] l;
  logic [NREQ-1:0]       prevg;
  int ord[$];
  int hold[$];
  int gap[$];
  int idle_run;
  int ndone;
  int ok;
  int dly;

  always #5 clk = ~clk;

  timer_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .len   (len),
    .grant (grant),
    .done  (done),
    .busy  (busy),
    .count (count)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int oh2i(input logic [NREQ-1:0] oh);
    int r;
    r = -1;
    for (int i = 0; i < NREQ; i++) if (oh[i]) r = i;
    return r;
  endfunction

  // Advance the model by one clock using the inputs the DUT sampled.
  task automatic model_edge();
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_done = -1; m_el = 0; m_len = 0;
    end else if (m_owner < 0) begin
      m_done = -1;
      for (int k = 0; k < NREQ; k++) begin
        int w;
        w = (m_ptr + k) % NREQ;
        if (req[w]) begin
          m_owner = w;
          m_len   = int'(len[w*WIDTH +: WIDTH]);
          m_el    = 0;
          m_ptr   = (w + 1) % NREQ;
          break;
        end
      end
    end else begin
      m_done = -1;
      if (!req[m_owner]) m_owner = -1;
      else if (m_el == m_len + 1) begin
        m_done  = m_owner;
        m_owner = -1;
      end else m_el++;
    end
  endtask

  task automatic check_model();
    logic [NREQ-1:0]  eg;
    logic [NREQ-1:0]  ed;
    logic [WIDTH-1:0] ec;
    eg = '0; ed = '0; ec = '0;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      // count shows L-elapsed, then the all-ones image of -1 on the underflow cycle
      ec = (m_el <= m_len) ? WIDTH'(m_len - m_el) : {WIDTH{1'b1}};
    end
    if (m_done >= 0) ed[m_done] = 1'b1;
    cmp("m_grant", 32'(grant), 32'(eg));
    cmp("m_done",  32'(done),  32'(ed));
    cmp("m_busy",  32'(busy),  (m_owner >= 0) ? 32'd1 : 32'd0);
    cmp("m_count", 32'(count), 32'(ec));
    cmp("inv_onehot", 32'($onehot0(grant) && $onehot0(done)), 32'd1);
    cmp("inv_same_idx", 32'((grant == '0) || (done == '0) || (grant == done)), 32'd1);
  endtask

  task automatic step(input logic r, input logic [NREQ-1:0] rq, input logic [NREQ*WIDTH-1:0] ln);
    rst = r; req = rq; len = ln;
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic reset_dut();
    step(1'b1, '0, '0);
    step(1'b1, '0, '0);
  endtask

  // Observe grant/done each cycle: grant order, hold lengths, idle gaps.
  task automatic observe();
    if (grant != '0 && grant != prevg) begin
      if (ord.size() > 0) gap.push_back(idle_run);
      ord.push_back(oh2i(grant));
      hold.push_back(1);
      idle_run = 0;
    end else if (grant != '0) begin
      hold[hold.size()-1] = hold[hold.size()-1] + 1;
    end else begin
      idle_run++;
    end
    if (done != '0) begin
      ndone++;
      if (ord.size() == 0 || done != (NREQ'(1) << ord[ord.size()-1])) ok = 0;
    end
    prevg = grant;
  endtask

  task automatic clear_obs();
    ord.delete(); hold.delete(); gap.delete();
    idle_run = 0; ndone = 0; ok = 1; prevg = '0;
  endtask

  function automatic int qget(input int qq[$], input int i);
    return (i < qq.size()) ? qq[i] : -1;
  endfunction

  initial begin
    rst = 1'b1; req = '0; len = '0;

    // ---- vector table: reset, then a single len=5 request on client 1 ----
    vt[0]  = '{1'b1, 4'b0001, 32'h0,         4'b0000, 4'b0000, 1'b0, 8'h00};
    vt[1]  = '{1'b1, 4'b0000, 32'h0,         4'b0000, 4'b0000, 1'b0, 8'h00};
    vt[2]  = '{1'b0, 4'b0010, 32'hABCD05EF,  4'b0010, 4'b0000, 1'b1, 8'h05};
    vt[3]  = '{1'b0, 4'b0010, 32'h0000FF00,  4'b0010, 4'b0000, 1'b1, 8'h04};
    vt[4]  = '{1'b0, 4'b0010, 32'h0000FF00,  4'b0010, 4'b0000, 1'b1, 8'h03};
    vt[5]  = '{1'b0, 4'b0010, 32'h0000FF00,  4'b0010, 4'b0000, 1'b1, 8'h02};
    vt[6]  = '{1'b0, 4'b0010, 32'h0000FF00,  4'b0010, 4'b0000, 1'b1, 8'h01};
    vt[7]  = '{1'b0, 4'b0010, 32'h0000FF00,  4'b0010, 4'b0000, 1'b1, 8'h00};
    vt[8]  = '{1'b0, 4'b0010, 32'h0000FF00,  4'b0010, 4'b0000, 1'b1, 8'hFF};
    vt[9]  = '{1'b0, 4'b0010, 32'h0000FF00,  4'b0000, 4'b0010, 1'b0, 8'h00};
    vt[10] = '{1'b0, 4'b0000, 32'h0000FF00,  4'b0000, 4'b0000, 1'b0, 8'h00};
    vt[11] = '{1'b0, 4'b0000, 32'h0,         4'b0000, 4'b0000, 1'b0, 8'h00};
    for (int i = 0; i < 12; i++) begin
      step(vt[i].rst, vt[i].req, vt[i].len);
      cmp($sformatf("v%0d_grant", i), 32'(grant), 32'(vt[i].grant));
      cmp($sformatf("v%0d_done", i),  32'(done),  32'(vt[i].done));
      cmp($sformatf("v%0d_busy", i),  32'(busy),  32'(vt[i].busy));
      cmp($sformatf("v%0d_count", i), 32'(count), 32'(vt[i].count));
    end

    // ---- all four clients, len 3,1,0,2, each releasing on its own done ----
    reset_dut();
    clear_obs();
    q = 4'b1111;
    l = {8'd2, 8'd0, 8'd1, 8'd3};
    for (int c = 0; c < 40; c++) begin
      step(1'b0, q, l);
      observe();
      q = q & ~done;
    end
    cmp("all4_ngrants", 32'(ord.size()), 32'd4);
    cmp("all4_ndone", 32'(ndone), 32'd4);
    cmp("all4_done_owner", 32'(ok), 32'd1);
    for (int i = 0; i < 4; i++) begin
      int eh[4];
      eh = '{5, 3, 2, 4};
      cmp($sformatf("all4_order%0d", i), 32'(qget(ord, i)), 32'(i));
      cmp($sformatf("all4_hold%0d", i), 32'(qget(hold, i)), 32'(eh[i]));
    end
    for (int i = 0; i < 3; i++) cmp($sformatf("all4_gap%0d", i), 32'(qget(gap, i)), 32'd1);

    // ---- clients 0 and 2 continuously, len 0: alternate grants ----
    reset_dut();
    clear_obs();
    for (int c = 0; c < 20; c++) begin
      step(1'b0, 4'b0101, '0);
      observe();
    end
    for (int i = 0; i < 4; i++) cmp($sformatf("alt_order%0d", i), 32'(qget(ord, i)), (i % 2 == 0) ? 32'd0 : 32'd2);
    cmp("alt_hold0", 32'(qget(hold, 0)), 32'd2);
    ok = 1;
    for (int i = 1; i < ord.size(); i++) if (ord[i] == ord[i-1]) ok = 0;
    cmp("alt_no_repeat", 32'(ok), 32'd1);

    // ---- abort: client 3, len 10, req dropped during the 4th RUN cycle ----
    reset_dut();
    l = {8'd10, 24'h0};
    for (int c = 0; c < 4; c++) step(1'b0, 4'b1000, l);
    cmp("abort_cnt4", 32'(count), 32'd7);
    step(1'b0, 4'b0000, l);
    cmp("abort_grant", 32'(grant), 32'd0);
    cmp("abort_done", 32'(done), 32'd0);
    cmp("abort_count", 32'(count), 32'd0);
    step(1'b0, 4'b0000, l);
    cmp("abort_done_after", 32'(done), 32'd0);

    // ---- reset mid-RUN at count 150 ----
    reset_dut();
    l = 32'h000000C8;
    ok = 0;
    for (int c = 0; c < 60 && ok == 0; c++) begin
      step(1'b0, 4'b0001, l);
      if (grant == 4'b0001 && count == 8'd150) ok = 1;
    end
    cmp("rst_reach150", 32'(ok), 32'd1);
    step(1'b1, 4'b0001, l);
    cmp("rst_grant", 32'(grant), 32'd0);
    cmp("rst_busy", 32'(busy), 32'd0);
    cmp("rst_count", 32'(count), 32'd0);
    cmp("rst_done", 32'(done), 32'd0);
    l = 32'h00070000;
    step(1'b0, 4'b0101, l);
    cmp("rst_ptr0", 32'(grant), 32'b0001);
    step(1'b0, 4'b0100, l);
    cmp("rst_drop0", 32'(grant), 32'd0);
    step(1'b0, 4'b0100, l);
    cmp("rst_c2_grant", 32'(grant), 32'b0100);
    cmp("rst_c2_count", 32'(count), 32'd7);

    // ---- boundary: len 255 ----
    reset_dut();
    l = 32'h0000FF00;
    step(1'b0, 4'b0010, l);
    cmp("b255_first", 32'(count), 32'd255);
    ok = 1; dly = -1;
    for (int k = 1; k <= 300 && dly < 0; k++) begin
      step(1'b0, 4'b0010, l);
      if (k <= 255 && count != WIDTH'(255 - k)) ok = 0;
      if (k <= 256 && grant != 4'b0010) ok = 0;
      if (done != '0) dly = k;
    end
    cmp("b255_seq", 32'(ok), 32'd1);
    cmp("b255_done_dly", 32'(dly), 32'd257);
    step(1'b0, 4'b0000, l);

    // ---- randomized traffic against the model ----
    reset_dut();
    q = '0; l = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < NREQ; b++) begin
        if ($urandom_range(0, 15) == 0) q[b] = ~q[b];
        if ($urandom_range(0, 7) == 0) l[b*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 255));
        else l[b*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 12));
      end
      step(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0, q, l);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
